ingress_pkt_fifo: RTL and testbench
===================================

Name: ingress_pkt_fifo

Overview:
Per-port packet-aware ingress FIFO that sits directly upstream of the 4-port round-robin input arbiter. One instance is used per ingress port.
- Write side: accepts a port's packet stream (sop/eop framed) at line rate, with no backpressure.
- Read side: exposes empty/rd_en/data to the arbiter. Read data appears one cycle after rd_en.
- Only complete packets become visible to the reader. Packets that do not fit are tail-dropped by rolling back the write pointer.

Parameters:
DATA_WIDTH, 64, word width; must match the arbiter data width.
ADDR_WIDTH, 9, log2 of depth (DEPTH = 2^ADDR_WIDTH words).
AFULL_THRESH, 2^ADDR_WIDTH-16, occupancy at or above which o_almost_full is asserted.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
i_wr_valid  in  1  write word valid.
i_wr_sop  in  1  first word of packet; qualified by i_wr_valid.
i_wr_eop  in  1  last word of packet; qualified by i_wr_valid. sop and eop in the same cycle means a 1-word packet.
i_wr_data  in  DATA_WIDTH  write word.
i_rd_en  in  1  read strobe from the arbiter.
o_rd_data  out  DATA_WIDTH  read word, registered, valid the cycle after an accepted rd_en.
o_empty  out  1  no committed words are available.
o_used  out  ADDR_WIDTH+1  occupancy: wr_ptr - rd_ptr, including any in-progress packet.
o_almost_full  out  1  o_used >= AFULL_THRESH.
o_drop_pulse  out  1  one-cycle pulse per dropped packet.
o_drop_cnt  out  16  dropped-packet count, saturating at 0xFFFF.
o_proto_err  out  1  one-cycle pulse when a word is received outside a packet.

Behaviour:
- Reset values: all pointers 0, state IDLE, o_rd_data 0, o_empty 1, o_used 0, o_almost_full 0, o_drop_pulse 0, o_drop_cnt 0, o_proto_err 0.
- Pointers: wr_ptr (speculative), cmt_ptr (committed), rd_ptr. Each is ADDR_WIDTH+1 bits and wraps naturally.
  - full = (wr_ptr - rd_ptr == DEPTH).
  - o_empty = (rd_ptr == cmt_ptr), decoded from registers.
- Memory: 1 write port and 1 read port, synchronous.
- Write FSM states: IDLE, RECV, DROP. A "write" means mem[wr_ptr] <= data and wr_ptr <= wr_ptr+1.
- IDLE:
  - valid & sop & ~full: write the word. If eop is also set, cmt_ptr <= wr_ptr+1 and stay in IDLE; otherwise go to RECV.
  - valid & sop & full: drop (pulse, count++). Go to DROP unless eop is set, in which case stay in IDLE.
  - valid & ~sop: discard the word, pulse o_proto_err, stay in IDLE.
- RECV:
  - valid & ~sop & ~full: write the word. If eop: cmt_ptr <= wr_ptr+1 and go to IDLE.
  - valid & ~sop & full: wr_ptr <= cmt_ptr, drop. If eop go to IDLE, else go to DROP.
  - valid & sop (missing eop): abort the current packet (wr_ptr <= cmt_ptr, drop). In the same cycle, start the new packet by writing at cmt_ptr; this write cannot be blocked by full. Next state follows the IDLE rules for the new packet.
- DROP:
  - Discard words until valid & eop, then go to IDLE.
  - valid & sop in DROP: start a new packet per the IDLE rules.
- Packets larger than DEPTH are always dropped, and no partial data is ever exposed.
- Read:
  - i_rd_en & ~o_empty: o_rd_data <= mem[rd_ptr] and rd_ptr++. Data is valid exactly 1 cycle after rd_en.
  - i_rd_en & o_empty: ignored; pointers unchanged and o_rd_data holds.
- Simultaneous read and write: independent. The full check uses the pre-edge rd_ptr, so a read in the same cycle does not free space for that write.
- Commit visibility: the eop word written at edge T makes o_empty fall after edge T. It is readable by an rd_en in cycle T+1.
- o_drop_cnt increments once per dropped packet and saturates at 0xFFFF.
- Reset mid-operation: clears all state immediately (asynchronous). Any partial packet is lost, and no stale words are readable after reset.

Test Plan:
- Reset, no traffic -> o_empty=1, o_rd_data=0, o_used=0, o_drop_cnt=0.
- Write a 4-word packet A0..A3 (sop on A0, eop on A3) -> o_empty stays 1 until the edge after A3. Then rd_en for 4 cycles -> o_rd_data = A0, A1, A2, A3, each 1 cycle after its rd_en. o_empty=1 after the 4th read edge.
- ADDR_WIDTH=4: write a 10-word packet, then an 8-word packet, with no reads -> the second packet is dropped at its 7th word. o_drop_pulse is asserted once, o_drop_cnt=1, o_used returns to 10, and only the 10 words are read out.
- 3 words sent, then a new sop without an intervening eop, then a 2-word packet B0/B1 -> first packet dropped, o_drop_cnt=1, reads return B0, B1 only.
- rd_en while empty, then a word with no sop in IDLE -> rd_ptr unchanged, o_rd_data holds its previous value, o_proto_err pulses once, o_used unchanged.
- rst_n asserted mid-packet after 5 words -> all outputs at reset values. A subsequent 1-word packet (sop=eop=1) becomes the first word read.

Source files
------------

// File: rtl/ingress_pkt_fifo_if.sv
// Write-stream, read-strobe and status bundle between a packet source, the
// ingress FIFO and its arbiter; master drives the inputs, slave is the FIFO.
interface ingress_pkt_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
);
  logic                  i_wr_valid;
  logic                  i_wr_sop;
  logic                  i_wr_eop;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_rd_en;

  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_empty;
  logic [ADDR_WIDTH:0]   o_used;
  logic                  o_almost_full;
  logic                  o_drop_pulse;
  logic [15:0]           o_drop_cnt;
  logic                  o_proto_err;

  modport master (
    output i_wr_valid, i_wr_sop, i_wr_eop, i_wr_data, i_rd_en,
    input  o_rd_data, o_empty, o_used, o_almost_full,
    input  o_drop_pulse, o_drop_cnt, o_proto_err
  );

  modport slave (
    input  i_wr_valid, i_wr_sop, i_wr_eop, i_wr_data, i_rd_en,
    output o_rd_data, o_empty, o_used, o_almost_full,
    output o_drop_pulse, o_drop_cnt, o_proto_err
  );
endinterface

// File: rtl/ingress_pkt_fifo.sv
// Packet-aware ingress FIFO: only whole packets become readable, packets that
// do not fit are tail-dropped by rolling wr_ptr back to the last commit point.
module ingress_pkt_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 16
) (
  input logic               clk,
  input logic               rst_n,
  ingress_pkt_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  state_t state, state_nxt;
  ptr_t   wr_ptr, wr_nxt;
  ptr_t   cmt_ptr, cmt_nxt;
  ptr_t   rd_ptr;
  ptr_t   used;
  ptr_t   waddr;
  logic   we;
  logic   drop;
  logic   proto;
  logic   full;
  logic   rd_fire;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [15:0]           drop_cnt;
  logic                  drop_pulse;
  logic                  proto_err;

  // Occupancy counts the in-progress packet too, so full guards speculative writes.
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == PTR_DEPTH);
  assign rd_fire = bus.i_rd_en && (rd_ptr != cmt_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cmt_nxt   = cmt_ptr;
    we        = 1'b0;
    waddr     = wr_ptr;
    drop      = 1'b0;
    proto     = 1'b0;
    if (bus.i_wr_valid) begin
      case (state)
        RECV: begin
          if (bus.i_wr_sop) begin
            // Abort the open packet and restart at the commit point; the
            // open packet held at least one word, so this slot is always free.
            drop   = 1'b1;
            we     = 1'b1;
            waddr  = cmt_ptr;
            wr_nxt = cmt_ptr + PTR_ONE;
            if (bus.i_wr_eop) begin
              cmt_nxt   = cmt_ptr + PTR_ONE;
              state_nxt = IDLE;
            end else begin
              state_nxt = RECV;
            end
          end else if (!full) begin
            we     = 1'b1;
            wr_nxt = wr_ptr + PTR_ONE;
            if (bus.i_wr_eop) begin
              cmt_nxt   = wr_ptr + PTR_ONE;
              state_nxt = IDLE;
            end
          end else begin
            wr_nxt    = cmt_ptr;
            drop      = 1'b1;
            state_nxt = bus.i_wr_eop ? IDLE : DROP;
          end
        end
        default: begin
          if (bus.i_wr_sop) begin
            if (!full) begin
              we     = 1'b1;
              wr_nxt = wr_ptr + PTR_ONE;
              if (bus.i_wr_eop) begin
                cmt_nxt   = wr_ptr + PTR_ONE;
                state_nxt = IDLE;
              end else begin
                state_nxt = RECV;
              end
            end else begin
              drop      = 1'b1;
              state_nxt = bus.i_wr_eop ? IDLE : DROP;
            end
          end else if (state == DROP) begin
            if (bus.i_wr_eop) begin
              state_nxt = IDLE;
            end
          end else begin
            proto     = 1'b1;
            state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      cmt_ptr <= cmt_nxt;
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Writes only land at or beyond cmt_ptr and reads only below it, so the
  // two ports never touch the same word in one cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[ADDR_WIDTH-1:0]] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_fire) begin
      rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      drop_pulse <= drop;
      proto_err  <= proto;
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign bus.o_rd_data     = rd_data;
  assign bus.o_empty       = (rd_ptr == cmt_ptr);
  assign bus.o_used        = used;
  assign bus.o_almost_full = (int'({1'b0, used}) >= AFULL_THRESH);
  assign bus.o_drop_pulse  = drop_pulse;
  assign bus.o_drop_cnt    = drop_cnt;
  assign bus.o_proto_err   = proto_err;

endmodule

// File: tb/tb_ingress_pkt_fifo.sv
// Bench for ingress_pkt_fifo: queue-based packet model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ingress_pkt_fifo;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TH    = 12;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 0;

  ingress_pkt_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ingress_pkt_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed words, words of the open packet, packet mode.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] pq[$];
  bit            m_in_pkt;
  bit            m_discard;
  logic [DW-1:0] m_rd_data;
  bit            m_drop;
  bit            m_proto;
  int            m_drop_cnt;
  int            used0;

  function automatic void m_commit();
    foreach (pq[k]) mq.push_back(pq[k]);
    pq.delete();
    m_in_pkt = 0;
  endfunction

  function automatic void m_count_drop();
    m_drop = 1;
    if (m_drop_cnt < 65535) m_drop_cnt++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pq.delete();
      m_in_pkt   = 0;
      m_discard  = 0;
      m_rd_data  = '0;
      m_drop     = 0;
      m_proto    = 0;
      m_drop_cnt = 0;
    end else begin
      used0   = mq.size() + pq.size();
      m_drop  = 0;
      m_proto = 0;
      if (bus.i_rd_en && mq.size() != 0) m_rd_data = mq.pop_front();
      if (bus.i_wr_valid) begin
        if (bus.i_wr_sop) begin
          if (m_in_pkt) begin
            pq.delete();
            m_count_drop();
            pq.push_back(bus.i_wr_data);
            if (bus.i_wr_eop) m_commit();
          end else if (used0 == DEPTH) begin
            m_count_drop();
            m_discard = !bus.i_wr_eop;
          end else begin
            m_discard = 0;
            pq.push_back(bus.i_wr_data);
            m_in_pkt = 1;
            if (bus.i_wr_eop) m_commit();
          end
        end else if (m_in_pkt) begin
          if (used0 == DEPTH) begin
            pq.delete();
            m_in_pkt = 0;
            m_count_drop();
            m_discard = !bus.i_wr_eop;
          end else begin
            pq.push_back(bus.i_wr_data);
            if (bus.i_wr_eop) m_commit();
          end
        end else if (m_discard) begin
          if (bus.i_wr_eop) m_discard = 0;
        end else begin
          m_proto = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rd_data",    bus.o_rd_data,     m_rd_data);
      check("empty",      bus.o_empty,       mq.size() == 0);
      check("used",       bus.o_used,        mq.size() + pq.size());
      check("almost_full", bus.o_almost_full, (mq.size() + pq.size()) >= TH);
      check("drop_pulse", bus.o_drop_pulse,  m_drop);
      check("drop_cnt",   bus.o_drop_cnt,    m_drop_cnt);
      check("proto_err",  bus.o_proto_err,   m_proto);
    end
  end

  task automatic step(input bit v, input bit s, input bit e, input logic [DW-1:0] d, input bit rd);
    bus.i_wr_valid = v;
    bus.i_wr_sop   = s;
    bus.i_wr_eop   = e;
    bus.i_wr_data  = d;
    bus.i_rd_en    = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.i_wr_valid = 0;
    bus.i_rd_en    = 0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_empty",    bus.o_empty,     1);
    check("rst_rd_data",  bus.o_rd_data,   0);
    check("rst_used",     bus.o_used,      0);
    check("rst_drop_cnt", bus.o_drop_cnt,  0);
    #2 rst_n = 1'b1;
  endtask

  logic [DW-1:0] held;

  initial begin
    rst_n          = 1'b1;
    bus.i_wr_valid = 0;
    bus.i_wr_sop   = 0;
    bus.i_wr_eop   = 0;
    bus.i_wr_data  = '0;
    bus.i_rd_en    = 0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1;
    @(negedge clk);
    check("init_empty",    bus.o_empty,    1);
    check("init_rd_data",  bus.o_rd_data,  0);
    check("init_used",     bus.o_used,     0);
    check("init_drop_cnt", bus.o_drop_cnt, 0);
    #2 rst_n = 1'b1;
    step(0, 0, 0, '0, 0);

    // 4-word packet, readable only after its eop edge
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, i == 3, 32'hA0 + i, 0);
      check("a_empty_wr", bus.o_empty, i != 3);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0, 1);
      check("a_rd", bus.o_rd_data, 32'hA0 + i);
    end
    check("a_empty_end", bus.o_empty, 1);

    // 10-word packet then 8-word packet that overflows at its 7th word
    for (int i = 0; i < 10; i++) step(1, i == 0, i == 9, 32'h100 + i, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, i == 7, 32'h200 + i, 0);
      if (i == 5) check("ovf_used_full", bus.o_used, 16);
      if (i == 6) begin
        check("ovf_drop_pulse", bus.o_drop_pulse, 1);
        check("ovf_drop_cnt",   bus.o_drop_cnt,   1);
        check("ovf_used",       bus.o_used,       10);
      end
    end
    check("ovf_pulse_once", bus.o_drop_pulse, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, '0, 1);
      check("ovf_rd", bus.o_rd_data, 32'h100 + i);
    end
    check("ovf_empty", bus.o_empty, 1);

    // Missing eop: 3 words, then a new 2-word packet aborts them
    for (int i = 0; i < 3; i++) step(1, i == 0, 0, 32'hC0 + i, 0);
    step(1, 1, 0, 32'hB0, 0);
    check("abort_drop_cnt", bus.o_drop_cnt, 2);
    step(1, 0, 1, 32'hB1, 0);
    check("abort_used", bus.o_used, 2);
    step(0, 0, 0, '0, 1);
    check("abort_rd0", bus.o_rd_data, 32'hB0);
    step(0, 0, 0, '0, 1);
    check("abort_rd1", bus.o_rd_data, 32'hB1);

    // Read while empty, then a stray word outside any packet
    held = bus.o_rd_data;
    step(0, 0, 0, '0, 1);
    check("empty_rd_hold", bus.o_rd_data, held);
    check("empty_rd_used", bus.o_used, 0);
    step(1, 0, 0, 32'hDEAD, 0);
    check("proto_pulse", bus.o_proto_err, 1);
    check("proto_used",  bus.o_used, 0);
    step(0, 0, 0, '0, 0);
    check("proto_clear", bus.o_proto_err, 0);

    // Reset in the middle of a packet
    for (int i = 0; i < 5; i++) step(1, i == 0, 0, 32'hE0 + i, 0);
    check("mid_used", bus.o_used, 5);
    do_reset();
    step(1, 1, 1, 32'h5A5A, 0);
    check("post_rst_empty", bus.o_empty, 0);
    step(0, 0, 0, '0, 1);
    check("post_rst_rd", bus.o_rd_data, 32'h5A5A);

    // Randomized traffic at several read rates
    for (int ph = 0; ph < 4; ph++) begin
      int rd_pct;
      rd_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 30;
      for (int c = 0; c < 1000; c++) begin
        step($urandom_range(0, 99) < 75,
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 20,
             $urandom(),
             $urandom_range(0, 99) < rd_pct);
      end
      if (ph == 1) do_reset();
    end

    step(0, 0, 0, '0, 0);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
